// File: rtl/mm_engine_arbiter.sv
// Round-robin arbiter that time-shares one 2x2 matrix-multiply engine between NUM_REQ requesters.
// Optional RUN-state watchdog is enabled by defining MM_ARB_TIMEOUT_EN.
module mm_engine_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               eng_rst,
  output logic               eng_en,
  input  logic               eng_done,
  input  logic [DATA_W-1:0]  eng_c11,
  input  logic [DATA_W-1:0]  eng_c12,
  input  logic [DATA_W-1:0]  eng_c21,
  input  logic [DATA_W-1:0]  eng_c22,
  output logic [DATA_W-1:0]  res_c11,
  output logic [DATA_W-1:0]  res_c12,
  output logic [DATA_W-1:0]  res_c21,
  output logic [DATA_W-1:0]  res_c22,
  output logic [NUM_REQ-1:0] res_valid,
  output logic               err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;     // index holding top priority
  logic [PTR_W-1:0]     idx_q, idx_d;     // index of the job in flight
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   res_valid_q, res_valid_d;
  logic                 busy_q, eng_rst_q, eng_en_q;
  logic [DATA_W-1:0]    res_c11_q, res_c12_q, res_c21_q, res_c22_q;
  logic                 load_res;
  logic                 timeout_hit;
  logic [PTR_W-1:0]     pick;

  // First requester at or above start, wrapping modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [PTR_W-1:0]   start);
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] cidx;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cidx = PTR_W'((int'(start) + i) % NUM_REQ);
      if (!found && r[cidx]) begin
        sel   = cidx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [PTR_W-1:0] after_idx(input logic [PTR_W-1:0] i);
    return PTR_W'((int'(i) + 1) % NUM_REQ);
  endfunction

`ifdef MM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q, err_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Counter sits at zero outside RUN, so it starts from zero on every RUN entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_RUN) ? cnt_q + 1'b1 : '0;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign pick = rr_pick(req, ptr_q);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    res_valid_d = '0;
    load_res    = 1'b0;
`ifdef MM_ARB_TIMEOUT_EN
    err_d       = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_RUN;
          idx_d   = pick;
          gnt_d   = NUM_REQ'(1) << pick;
        end
      end
      S_RUN: begin
        if (eng_done) begin
          state_d     = S_CLEAR;
          load_res    = 1'b1;
          res_valid_d = gnt_q;
          gnt_d       = '0;
          ptr_d       = after_idx(idx_q);
        end else if (timeout_hit) begin
          state_d     = S_CLEAR;
          res_valid_d = gnt_q;
          gnt_d       = '0;
          ptr_d       = after_idx(idx_q);
`ifdef MM_ARB_TIMEOUT_EN
          err_d       = 1'b1;
`endif
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      res_valid_q <= '0;
      busy_q      <= 1'b0;
      eng_rst_q   <= 1'b1;
      eng_en_q    <= 1'b0;
      res_c11_q   <= '0;
      res_c12_q   <= '0;
      res_c21_q   <= '0;
      res_c22_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      // Engine controls are decoded from the next state so they are registered yet aligned with it.
      busy_q      <= (state_d != S_IDLE);
      eng_rst_q   <= (state_d != S_RUN);
      eng_en_q    <= (state_d == S_RUN);
      if (load_res) begin
        res_c11_q <= eng_c11;
        res_c12_q <= eng_c12;
        res_c21_q <= eng_c21;
        res_c22_q <= eng_c22;
      end
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign eng_rst   = eng_rst_q;
  assign eng_en    = eng_en_q;
  assign res_c11   = res_c11_q;
  assign res_c12   = res_c12_q;
  assign res_c21   = res_c21_q;
  assign res_c22   = res_c22_q;

endmodule

// File: tb/tb_mm_engine_arbiter.sv
// Self-checking bench for mm_engine_arbiter: round-robin model, randomized jobs and engine latency.
// The timeout scenario is compiled in only when MM_ARB_TIMEOUT_EN is defined.
module tb_mm_engine_arbiter;
  localparam int N  = 2;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           busy, eng_rst, eng_en, eng_done, err;
  logic [W-1:0]   eng_c11, eng_c12, eng_c21, eng_c22;
  logic [W-1:0]   res_c11, res_c12, res_c21, res_c22;
  logic [N-1:0]   res_valid;

  int checks   = 0;
  int failures = 0;

  // Reference model: priority start index and the last completed result.
  int           m_ptr;
  logic [4*W-1:0] m_res;

  mm_engine_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .busy(busy),
    .eng_rst(eng_rst), .eng_en(eng_en), .eng_done(eng_done),
    .eng_c11(eng_c11), .eng_c12(eng_c12), .eng_c21(eng_c21), .eng_c22(eng_c22),
    .res_c11(res_c11), .res_c12(res_c12), .res_c21(res_c21), .res_c22(res_c22),
    .res_valid(res_valid), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic junk_data();
    {eng_c11, eng_c12, eng_c21, eng_c22} = {$urandom(), $urandom()};
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; eng_done = 1'b0; junk_data();
    repeat (3) @(negedge clk);
    m_ptr = 0;
    m_res = '0;
  endtask

  // One complete job: grant, engine latency, done, result pulse. Returns at the res_valid cycle.
  task automatic run_job(input logic [N-1:0] r, input int lat, input bit drop,
                         input logic [4*W-1:0] vals, input int exp_wait,
                         input string tag, output int w);
    logic [N-1:0] exp_g;
    int waited;
    req = r;
    w = model_pick(r);
    exp_g = '0;
    exp_g[w] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (gnt === '0 && waited < 10);
    checks++; if (gnt !== exp_g) begin failures++; $display("FAIL %s gnt: got %b want %b", tag, gnt, exp_g); end
    if (exp_wait >= 0) begin
      checks++; if (waited != exp_wait) begin failures++; $display("FAIL %s grant latency: got %0d want %0d", tag, waited, exp_wait); end
    end
    checks++; if ({eng_en, eng_rst, busy} !== 3'b101) begin failures++; $display("FAIL %s run ctrl en/rst/busy: got %b want 101", tag, {eng_en, eng_rst, busy}); end
    for (int k = 1; k < lat; k++) begin
      if (drop && k == lat / 2) req[w] = 1'b0;
      junk_data();
      @(negedge clk);
    end
    checks++; if (eng_en !== 1'b1 || gnt !== exp_g || res_valid !== '0) begin failures++; $display("FAIL %s hold: en=%b gnt=%b rv=%b want 1/%b/0", tag, eng_en, gnt, res_valid, exp_g); end
    eng_done = 1'b1;
    {eng_c11, eng_c12, eng_c21, eng_c22} = vals;
    @(negedge clk);
    eng_done = 1'b0;
    junk_data();
    m_ptr = (w + 1) % N;
    m_res = vals;
    checks++; if (res_valid !== exp_g) begin failures++; $display("FAIL %s res_valid: got %b want %b", tag, res_valid, exp_g); end
    checks++; if ({res_c11, res_c12, res_c21, res_c22} !== m_res) begin failures++; $display("FAIL %s res: got %h want %h", tag, {res_c11, res_c12, res_c21, res_c22}, m_res); end
    checks++; if ({gnt, eng_en, eng_rst, busy, err} !== {{N{1'b0}}, 4'b0110}) begin failures++; $display("FAIL %s clear ctrl gnt/en/rst/busy/err: got %b", tag, {gnt, eng_en, eng_rst, busy, err}); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({eng_rst, eng_en, busy, gnt, res_valid, err} !== {3'b100, {N{1'b0}}, {N{1'b0}}, 1'b0}) begin failures++; $display("FAIL reset ctrl: got rst/en/busy=%b%b%b gnt=%b rv=%b err=%b", eng_rst, eng_en, busy, gnt, res_valid, err); end
    checks++; if ({res_c11, res_c12, res_c21, res_c22} !== '0) begin failures++; $display("FAIL reset res: got %h want 0", {res_c11, res_c12, res_c21, res_c22}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({eng_rst, eng_en, busy, gnt} !== {3'b100, {N{1'b0}}}) begin failures++; $display("FAIL reset idle: got rst/en/busy=%b%b%b gnt=%b", eng_rst, eng_en, busy, gnt); end
  endtask

  task automatic test_single();
    int w;
    run_job(2'b01, 10, 1'b0, {8'd19, 8'd22, 8'd43, 8'd50}, 1, "single", w);
    req = '0;
    @(negedge clk);
    checks++; if ({res_valid, eng_rst, busy} !== {{N{1'b0}}, 2'b10}) begin failures++; $display("FAIL single after: rv=%b rst=%b busy=%b want 0/1/0", res_valid, eng_rst, busy); end
    checks++; if ({res_c11, res_c12, res_c21, res_c22} !== {8'd19, 8'd22, 8'd43, 8'd50}) begin failures++; $display("FAIL single res hold: got %h", {res_c11, res_c12, res_c21, res_c22}); end
  endtask

  task automatic test_contention();
    int w;
    logic [N-1:0] want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      run_job(2'b11, $urandom_range(8, 1), 1'b0, {$urandom(), $urandom()}, (j == 0) ? 1 : 2, "contention", w);
      checks++; if (w != ((want[j] == 2'b01) ? 0 : 1)) begin failures++; $display("FAIL contention order job %0d: got idx %0d want %b", j, w, want[j]); end
    end
    req = '0;
  endtask

  task automatic test_drop();
    int w;
    run_job(2'b01, 8, 1'b1, {$urandom(), $urandom()}, -1, "drop", w);
    req = '0;
  endtask

  task automatic test_done_outside();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      eng_done = $urandom_range(1, 0);
      junk_data();
    end
    @(negedge clk);
    eng_done = 1'b0;
    checks++; if ({busy, res_valid, eng_en} !== {1'b0, {N{1'b0}}, 1'b0}) begin failures++; $display("FAIL done_outside ctrl: busy=%b rv=%b en=%b", busy, res_valid, eng_en); end
    checks++; if ({res_c11, res_c12, res_c21, res_c22} !== m_res) begin failures++; $display("FAIL done_outside res: got %h want %h", {res_c11, res_c12, res_c21, res_c22}, m_res); end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    rst = 1'b0;
    run_job(2'b01, 3, 1'b0, {$urandom(), $urandom()}, 1, "mid_pre", w);
    req = 2'b11;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL mid grant: got %b want 10", gnt); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_res = '0;
    checks++; if ({eng_en, eng_rst, busy, gnt, res_valid} !== {3'b010, {N{1'b0}}, {N{1'b0}}}) begin failures++; $display("FAIL mid reset ctrl: en/rst/busy=%b%b%b gnt=%b rv=%b", eng_en, eng_rst, busy, gnt, res_valid); end
    run_job(2'b11, 4, 1'b0, {$urandom(), $urandom()}, 1, "mid_post", w);
    checks++; if (w != 0) begin failures++; $display("FAIL mid pointer reset: got idx %0d want 0", w); end
    req = '0;
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] r;
    for (int j = 0; j < 12; j++) begin
      r = N'($urandom_range(3, 1));
      run_job(r, $urandom_range(12, 1), 1'($urandom_range(1, 0)), {$urandom(), $urandom()}, (j == 0) ? -1 : 2, "random", w);
    end
    req = '0;
  endtask

`ifdef MM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int w, waited;
    logic [N-1:0] exp_g;
    repeat (3) @(negedge clk);
    req = 2'b01;
    w = model_pick(req);
    exp_g = '0;
    exp_g[w] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (gnt === '0 && waited < 10);
    checks++; if (gnt !== exp_g) begin failures++; $display("FAIL timeout gnt: got %b want %b", gnt, exp_g); end
    waited = 0;
    do begin junk_data(); @(negedge clk); waited++; end while (res_valid === '0 && waited < 40);
    m_ptr = (w + 1) % N;
    checks++; if (waited != TO) begin failures++; $display("FAIL timeout latency: got %0d want %0d", waited, TO); end
    checks++; if ({res_valid, err} !== {exp_g, 1'b1}) begin failures++; $display("FAIL timeout pulse: rv=%b err=%b want %b/1", res_valid, err, exp_g); end
    checks++; if ({res_c11, res_c12, res_c21, res_c22} !== m_res) begin failures++; $display("FAIL timeout res: got %h want %h", {res_c11, res_c12, res_c21, res_c22}, m_res); end
    req = '0;
    test_random();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_drop();
    test_done_outside();
    test_reset_mid();
    test_random();
`ifdef MM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
